// File: rtl/window_lane_arbiter_if.sv
// Window bus between two event-scheduler lanes, the lane arbiter and the shared sobel3 stage.
// Valid signals are one-cycle data pulses; req signals are level "ready for new" indications.
interface window_lane_arbiter_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 16
);
  localparam int WIN_W = 9 * DATA_WIDTH;

  logic [WIN_W-1:0]      in_window_value_0;
  logic [WIN_W-1:0]      in_window_value_1;
  logic [ADDR_WIDTH-1:0] in_window_addr_0;
  logic [ADDR_WIDTH-1:0] in_window_addr_1;
  logic                  in_window_valid_0;
  logic                  in_window_valid_1;
  logic                  out_window_req_0;
  logic                  out_window_req_1;
  logic [WIN_W-1:0]      out_window_value;
  logic [ADDR_WIDTH-1:0] out_window_addr;
  logic                  out_window_valid;
  logic                  out_window_lane;
  logic                  in_window_req;

  modport slave (
    input  in_window_value_0, in_window_value_1,
    input  in_window_addr_0, in_window_addr_1,
    input  in_window_valid_0, in_window_valid_1,
    input  in_window_req,
    output out_window_req_0, out_window_req_1,
    output out_window_value, out_window_addr,
    output out_window_valid, out_window_lane
  );

  modport master (
    output in_window_value_0, in_window_value_1,
    output in_window_addr_0, in_window_addr_1,
    output in_window_valid_0, in_window_valid_1,
    output in_window_req,
    input  out_window_req_0, out_window_req_1,
    input  out_window_value, out_window_addr,
    input  out_window_valid, out_window_lane
  );
endinterface

// File: rtl/window_lane_arbiter.sv
// Round-robin, burst-limited arbiter sharing one sobel3 stage between two window lanes.
// Optional grant/stall counters are enabled by defining WINDOW_ARB_STATS_EN.
module window_lane_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int BCNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  window_lane_arbiter_if.slave  bus,
  output logic                  ovf_err,
  output logic [31:0]           stat_grants_0,
  output logic [31:0]           stat_grants_1,
  output logic [31:0]           stat_stall
);

  localparam int WIN_W = 9 * DATA_WIDTH;
  localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(BURST_LEN);

  typedef enum logic {OWN0, OWN1} state_t;

  state_t                state, state_nxt;
  logic [BCNT_W-1:0]     bcnt, bcnt_nxt;
  logic [1:0]            hold_vld;
  logic [1:0]            in_vld;
  logic [WIN_W-1:0]      hold_value [2];
  logic [ADDR_WIDTH-1:0] hold_addr [2];
  logic [WIN_W-1:0]      in_value [2];
  logic [ADDR_WIDTH-1:0] in_addr [2];
  logic                  issue;
  logic                  gnt;
  logic                  owner;
  logic                  other;

  assign in_vld      = {bus.in_window_valid_1, bus.in_window_valid_0};
  assign in_value[0] = bus.in_window_value_0;
  assign in_value[1] = bus.in_window_value_1;
  assign in_addr[0]  = bus.in_window_addr_0;
  assign in_addr[1]  = bus.in_window_addr_1;

  assign bus.out_window_req_0 = ~hold_vld[0];
  assign bus.out_window_req_1 = ~hold_vld[1];

  assign owner = (state == OWN1);
  assign other = ~owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OWN0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // Owner keeps the grant until its burst is spent, then yields only if the other lane is waiting.
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    issue     = 1'b0;
    gnt       = owner;
    if (bus.in_window_req) begin
      if (hold_vld[owner] && (bcnt < BURST_MAX)) begin
        issue    = 1'b1;
        bcnt_nxt = bcnt + BCNT_W'(1);
      end else if (hold_vld[other]) begin
        issue     = 1'b1;
        gnt       = other;
        state_nxt = other ? OWN1 : OWN0;
        bcnt_nxt  = BCNT_W'(1);
      end else if (hold_vld[owner]) begin
        issue    = 1'b1;
        bcnt_nxt = BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld <= '0;
      ovf_err  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        hold_value[i] <= '0;
        hold_addr[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (issue && (gnt == 1'(i))) begin
          hold_vld[i] <= 1'b0;
        end
        // A full hold can never also be refilled here, so issue and capture never collide.
        if (in_vld[i]) begin
          if (hold_vld[i]) begin
            ovf_err <= 1'b1;
          end else begin
            hold_vld[i]   <= 1'b1;
            hold_value[i] <= in_value[i];
            hold_addr[i]  <= in_addr[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_window_valid <= 1'b0;
      bus.out_window_value <= '0;
      bus.out_window_addr  <= '0;
      bus.out_window_lane  <= 1'b0;
    end else begin
      bus.out_window_valid <= issue;
      if (issue) begin
        bus.out_window_value <= hold_value[gnt];
        bus.out_window_addr  <= hold_addr[gnt];
        bus.out_window_lane  <= gnt;
      end
    end
  end

`ifdef WINDOW_ARB_STATS_EN
  logic [31:0] grants_0_q;
  logic [31:0] grants_1_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grants_0_q <= '0;
      grants_1_q <= '0;
      stall_q    <= '0;
    end else begin
      if (issue && !gnt) grants_0_q <= grants_0_q + 32'd1;
      if (issue && gnt)  grants_1_q <= grants_1_q + 32'd1;
      // Should never count: a full hold with downstream ready always wins a grant.
      if (bus.in_window_req && (|hold_vld) && !issue) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_grants_0 = grants_0_q;
  assign stat_grants_1 = grants_1_q;
  assign stat_stall    = stall_q;
`else
  assign stat_grants_0 = 32'd0;
  assign stat_grants_1 = 32'd0;
  assign stat_stall    = 32'd0;
`endif

endmodule

// File: tb/tb_window_lane_arbiter.sv
// Directed bench for window_lane_arbiter: reset, single lane, backpressure, overflow, burst and stats.
module tb_window_lane_arbiter;
  localparam int DW    = 4;
  localparam int AW    = 16;
  localparam int WIN_W = 9 * DW;

`ifdef WINDOW_ARB_STATS_EN
  localparam logic [31:0] EXP_G0 = 32'd8;
  localparam logic [31:0] EXP_G1 = 32'd8;
`else
  localparam logic [31:0] EXP_G0 = 32'd0;
  localparam logic [31:0] EXP_G1 = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ovf_err;
  logic [31:0] stat_grants_0, stat_grants_1, stat_stall;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  window_lane_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  window_lane_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .ovf_err       (ovf_err),
    .stat_grants_0 (stat_grants_0),
    .stat_grants_1 (stat_grants_1),
    .stat_stall    (stat_stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_window_valid_0 = 1'b0;
    bus.in_window_valid_1 = 1'b0;
    bus.in_window_value_0 = '0;
    bus.in_window_value_1 = '0;
    bus.in_window_addr_0  = '0;
    bus.in_window_addr_1  = '0;
    bus.in_window_req     = 1'b0;
    #3;
    n_checks++; if (bus.out_window_req_0 !== 1'b1) $display("FAIL reset_req0: got %b want 1", bus.out_window_req_0); else n_pass++;
    n_checks++; if (bus.out_window_req_1 !== 1'b1) $display("FAIL reset_req1: got %b want 1", bus.out_window_req_1); else n_pass++;
    n_checks++; if (bus.out_window_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_window_valid); else n_pass++;
    n_checks++; if (bus.out_window_addr !== 16'h0) $display("FAIL reset_addr: got %h want 0", bus.out_window_addr); else n_pass++;
    n_checks++; if (ovf_err !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_err); else n_pass++;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_lane();
    logic [WIN_W-1:0] v;
    do_reset();
    bus.in_window_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v = 36'h123456780 + WIN_W'(k);
      bus.in_window_valid_0 = 1'b1;
      bus.in_window_addr_0  = 16'h0010 + 16'(k);
      bus.in_window_value_0 = v;
      step();
      bus.in_window_valid_0 = 1'b0;
      n_checks++; if (bus.out_window_req_0 !== 1'b0) $display("FAIL single_req_low[%0d]: got %b want 0", k, bus.out_window_req_0); else n_pass++;
      n_checks++; if (bus.out_window_valid !== 1'b0) $display("FAIL single_early_valid[%0d]: got %b want 0", k, bus.out_window_valid); else n_pass++;
      step();
      n_checks++; if (bus.out_window_valid !== 1'b1) $display("FAIL single_valid[%0d]: got %b want 1", k, bus.out_window_valid); else n_pass++;
      n_checks++; if (bus.out_window_addr !== 16'h0010 + 16'(k)) $display("FAIL single_addr[%0d]: got %h want %h", k, bus.out_window_addr, 16'h0010 + 16'(k)); else n_pass++;
      n_checks++; if (bus.out_window_value !== v) $display("FAIL single_value[%0d]: got %h want %h", k, bus.out_window_value, v); else n_pass++;
      n_checks++; if (bus.out_window_lane !== 1'b0) $display("FAIL single_lane[%0d]: got %b want 0", k, bus.out_window_lane); else n_pass++;
      n_checks++; if (bus.out_window_req_0 !== 1'b1) $display("FAIL single_req_back[%0d]: got %b want 1", k, bus.out_window_req_0); else n_pass++;
    end
    step();
    n_checks++; if (bus.out_window_valid !== 1'b0) $display("FAIL single_pulse_end: got %b want 0", bus.out_window_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.in_window_req     = 1'b0;
    bus.in_window_valid_0 = 1'b1;
    bus.in_window_addr_0  = 16'h00A0;
    bus.in_window_valid_1 = 1'b1;
    bus.in_window_addr_1  = 16'h00B0;
    step();
    bus.in_window_valid_0 = 1'b0;
    bus.in_window_valid_1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (bus.out_window_valid !== 1'b0 || bus.out_window_req_0 !== 1'b0 || bus.out_window_req_1 !== 1'b0)
        $display("FAIL bp_hold[%0d]: got valid=%b req0=%b req1=%b want 0/0/0", c,
                 bus.out_window_valid, bus.out_window_req_0, bus.out_window_req_1);
      else n_pass++;
      step();
    end
    bus.in_window_req = 1'b1;
    step();
    n_checks++; if (bus.out_window_valid !== 1'b1 || bus.out_window_lane !== 1'b0 || bus.out_window_addr !== 16'h00A0)
      $display("FAIL bp_first: got v=%b lane=%b addr=%h want 1/0/00a0", bus.out_window_valid, bus.out_window_lane, bus.out_window_addr); else n_pass++;
    step();
    n_checks++; if (bus.out_window_valid !== 1'b1 || bus.out_window_lane !== 1'b1 || bus.out_window_addr !== 16'h00B0)
      $display("FAIL bp_second: got v=%b lane=%b addr=%h want 1/1/00b0", bus.out_window_valid, bus.out_window_lane, bus.out_window_addr); else n_pass++;
    step();
    n_checks++; if (bus.out_window_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", bus.out_window_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    bus.in_window_req     = 1'b0;
    bus.in_window_valid_1 = 1'b1;
    bus.in_window_addr_1  = 16'h00C1;
    bus.in_window_value_1 = 36'h111111111;
    step();
    n_checks++; if (ovf_err !== 1'b0) $display("FAIL ovf_early: got %b want 0", ovf_err); else n_pass++;
    bus.in_window_addr_1  = 16'h00DD;
    bus.in_window_value_1 = 36'h999999999;
    step();
    bus.in_window_valid_1 = 1'b0;
    n_checks++; if (ovf_err !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf_err); else n_pass++;
    step();
    step();
    bus.in_window_req = 1'b1;
    step();
    n_checks++; if (bus.out_window_valid !== 1'b1 || bus.out_window_lane !== 1'b1 || bus.out_window_addr !== 16'h00C1)
      $display("FAIL ovf_issue: got v=%b lane=%b addr=%h want 1/1/00c1", bus.out_window_valid, bus.out_window_lane, bus.out_window_addr); else n_pass++;
    n_checks++; if (bus.out_window_value !== 36'h111111111) $display("FAIL ovf_value: got %h want 111111111", bus.out_window_value); else n_pass++;
    step();
    n_checks++; if (bus.out_window_valid !== 1'b0) $display("FAIL ovf_no_extra: got %b want 0", bus.out_window_valid); else n_pass++;
    n_checks++; if (ovf_err !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf_err); else n_pass++;
  endtask

  task automatic test_burst();
    int          e_lane [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    logic [15:0] nxt0, nxt1, exp0, exp1, exp_addr;
    do_reset();
    nxt0 = 16'h0100; nxt1 = 16'h0200;
    exp0 = 16'h0100; exp1 = 16'h0200;
    bus.in_window_req     = 1'b0;
    bus.in_window_valid_0 = 1'b1;
    bus.in_window_addr_0  = nxt0;
    bus.in_window_valid_1 = 1'b1;
    bus.in_window_addr_1  = nxt1;
    nxt0++; nxt1++;
    step();
    bus.in_window_valid_0 = 1'b0;
    bus.in_window_valid_1 = 1'b0;
    for (int n = 0; n < 16; n++) begin
      bus.in_window_req = 1'b1;
      step();
      bus.in_window_req = 1'b0;
      exp_addr = (e_lane[n] == 1) ? exp1 : exp0;
      n_checks++; if (bus.out_window_valid !== 1'b1) $display("FAIL burst_valid[%0d]: got %b want 1", n, bus.out_window_valid); else n_pass++;
      n_checks++; if (bus.out_window_lane !== 1'(e_lane[n])) $display("FAIL burst_lane[%0d]: got %b want %0d", n, bus.out_window_lane, e_lane[n]); else n_pass++;
      n_checks++; if (bus.out_window_addr !== exp_addr) $display("FAIL burst_addr[%0d]: got %h want %h", n, bus.out_window_addr, exp_addr); else n_pass++;
      if (e_lane[n] == 1) exp1++; else exp0++;
      if (bus.out_window_req_0) begin
        bus.in_window_valid_0 = 1'b1;
        bus.in_window_addr_0  = nxt0;
        nxt0++;
      end
      if (bus.out_window_req_1) begin
        bus.in_window_valid_1 = 1'b1;
        bus.in_window_addr_1  = nxt1;
        nxt1++;
      end
      step();
      bus.in_window_valid_0 = 1'b0;
      bus.in_window_valid_1 = 1'b0;
    end
    n_checks++; if (stat_grants_0 !== EXP_G0) $display("FAIL stat_g0: got %0d want %0d", stat_grants_0, EXP_G0); else n_pass++;
    n_checks++; if (stat_grants_1 !== EXP_G1) $display("FAIL stat_g1: got %0d want %0d", stat_grants_1, EXP_G1); else n_pass++;
    n_checks++; if (stat_stall !== 32'd0) $display("FAIL stat_stall: got %0d want 0", stat_stall); else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    int seen;
    do_reset();
    bus.in_window_req     = 1'b0;
    bus.in_window_valid_0 = 1'b1;
    bus.in_window_addr_0  = 16'h0E00;
    bus.in_window_valid_1 = 1'b1;
    bus.in_window_addr_1  = 16'h0E01;
    step();
    bus.in_window_valid_0 = 1'b0;
    bus.in_window_valid_1 = 1'b0;
    n_checks++; if (bus.out_window_req_0 !== 1'b0 || bus.out_window_req_1 !== 1'b0)
      $display("FAIL mid_full: got req0=%b req1=%b want 0/0", bus.out_window_req_0, bus.out_window_req_1); else n_pass++;
    bus.in_window_req = 1'b1;
    step();
    bus.in_window_req = 1'b0;
    n_checks++; if (bus.out_window_valid !== 1'b1) $display("FAIL mid_issue: got %b want 1", bus.out_window_valid); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.out_window_valid !== 1'b0) $display("FAIL mid_async_valid: got %b want 0", bus.out_window_valid); else n_pass++;
    n_checks++; if (bus.out_window_req_0 !== 1'b1 || bus.out_window_req_1 !== 1'b1)
      $display("FAIL mid_async_req: got req0=%b req1=%b want 1/1", bus.out_window_req_0, bus.out_window_req_1); else n_pass++;
    step();
    rst = 1'b0;
    bus.in_window_req = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.out_window_valid) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL mid_discard: got %0d outputs want 0", seen); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_backpressure();
    test_overflow();
    test_burst();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
